// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a core and data_mem_ctrl
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  modport master (output req_valid, req_op, addr, wdata, pc, input req_ready, resp_valid, rdata, err);
  modport slave (input req_valid, req_op, addr, wdata, pc, output req_ready, resp_valid, rdata, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency 32-bit data memory with byte/halfword loads, RMW stores and fault detection
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 1
) (
  input logic         clk,
  input logic         reset,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic [2:0]  r_op, op;
  logic [31:0] r_addr, r_wdata, r_pc, a, wd, pcv;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] w, ld, mrg;
  logic [AW-1:0] wi;
  logic [4:0]  sh, hs;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        accept, commit, store, mis, oor, fault;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt <= 3'd1 ? RESP : WAIT)
             : IDLE;
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == RESP;
  end
  // With LATENCY=1 the commit edge is the accept edge, so operands bypass the latches
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    commit = state != RESP && state_nx == RESP;
    op     = state == IDLE ? bus.req_op : r_op;
    a      = state == IDLE ? bus.addr : r_addr;
    wd     = state == IDLE ? bus.wdata : r_wdata;
    pcv    = state == IDLE ? bus.pc : r_pc;
    wi     = a[AW+1:2];
    w      = mem[wi];
    sh     = {a[1:0], 3'b000};
    hs     = {a[1], 4'b0000};
    byte_v = 8'(w >> sh);
    half_v = 16'(w >> hs);
    store  = op >= 3'd5;
    mis    = (op == 3'd0 || op == 3'd5) ? a[1:0] != 2'b00 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? a[0] : 1'b0;
    oor    = {2'b00, a[31:2]} >= 32'(DEPTH_WORDS);
    fault  = mis || oor;
    ld     = op == 3'd0 ? w
           : op == 3'd1 ? {{16{half_v[15]}}, half_v}
           : op == 3'd2 ? {16'h0000, half_v}
           : op == 3'd3 ? {{24{byte_v[7]}}, byte_v}
           : {24'h000000, byte_v};
    mrg    = op == 3'd5 ? wd
           : op == 3'd6 ? (w & ~(32'h0000FFFF << hs)) | ({16'h0000, wd[15:0]} << hs)
           : (w & ~(32'h000000FF << sh)) | ({24'h000000, wd[7:0]} << sh);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      cnt       <= '0;
      r_op      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pc      <= '0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
    end else begin
      if (accept) begin
        r_op    <= bus.req_op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_pc    <= bus.pc;
        cnt     <= 3'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 3'd1;
      if (commit) begin
        bus.err   <= fault;
        bus.rdata <= (fault || store) ? 32'h0 : ld;
      end
    end
  always_ff @(posedge clk)
    if (!reset) for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    else if (commit && store && !fault) mem[wi] <= mrg;
`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && commit && store && !fault)
      $display("@%08h: *%08h <= %08h", pcv, {a[31:2], 2'b00}, mrg);
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl at LATENCY=1 and LATENCY=3
module tb_data_mem_ctrl;
  logic clk = 0, rst1, rst3;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  data_mem_ctrl_if m1();
  data_mem_ctrl_if m3();
  data_mem_ctrl #(.DEPTH_WORDS(3072), .LATENCY(1)) u1 (.clk(clk), .reset(rst1), .bus(m1.slave));
  data_mem_ctrl #(.DEPTH_WORDS(16), .LATENCY(3)) u3 (.clk(clk), .reset(rst3), .bus(m3.slave));

  task automatic xfer(input int u, input logic [2:0] op, input logic [31:0] ad, input logic [31:0] wdv,
                      output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    if (u == 1) begin m1.req_valid = 1; m1.req_op = op; m1.addr = ad; m1.wdata = wdv; m1.pc = 32'h100 + ad; end
    else begin m3.req_valid = 1; m3.req_op = op; m3.addr = ad; m3.wdata = wdv; m3.pc = 32'h200 + ad; end
    @(posedge clk);
    #1;
    m1.req_valid = 0;
    m3.req_valid = 0;
    lat = 0; rd = 'x; er = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if ((u == 1 ? m1.resp_valid : m3.resp_valid) === 1'b1) begin
        lat = n;
        rd = u == 1 ? m1.rdata : m3.rdata;
        er = u == 1 ? m1.err : m3.err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat; logic [31:0] rd; logic er;
    rst1 = 0; rst3 = 0;
    m1.req_valid = 1; m1.req_op = 3'd5; m1.addr = 32'h10; m1.wdata = 32'hFFFFFFFF; m1.pc = 0;
    m3.req_valid = 0; m3.req_op = 0; m3.addr = 0; m3.wdata = 0; m3.pc = 0;
    repeat (3) @(negedge clk);
    total++; if (m1.resp_valid !== 1'b0) $display("FAIL rst_resp_in_reset got=%b exp=0", m1.resp_valid); else pass++;
    rst1 = 1; rst3 = 1; m1.req_valid = 0;
    @(negedge clk);
    total++; if (m1.resp_valid !== 1'b0) $display("FAIL rst_no_accept got=%b exp=0", m1.resp_valid); else pass++;
    total++; if (m1.req_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", m1.req_ready); else pass++;
    total++; if (m1.rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=00000000", m1.rdata); else pass++;
    total++; if (m1.err !== 1'b0) $display("FAIL rst_err got=%b exp=0", m1.err); else pass++;
    total++; if (m3.req_ready !== 1'b1 || m3.resp_valid !== 1'b0) $display("FAIL rst3_state got=%b%b exp=10", m3.req_ready, m3.resp_valid); else pass++;
    xfer(1, 3'd0, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'h0) $display("FAIL rst_mem_clear got=%h exp=00000000", rd); else pass++;
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic er;
    xfer(1, 3'd5, 32'h10, 32'h8899AABB, lat, rd, er);
    total++; if (lat !== 1) $display("FAIL sw_latency got=%0d exp=1", lat); else pass++;
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_resp got=%h/%b exp=00000000/0", rd, er); else pass++;
    xfer(1, 3'd3, 32'h12, 0, lat, rd, er);
    total++; if (lat !== 1) $display("FAIL lb_latency got=%0d exp=1", lat); else pass++;
    total++; if (rd !== 32'hFFFFFF99 || er !== 1'b0) $display("FAIL lb got=%h/%b exp=ffffff99/0", rd, er); else pass++;
  endtask

  task automatic test_load_ext;
    int lat; logic [31:0] rd; logic er;
    xfer(1, 3'd4, 32'h12, 0, lat, rd, er);
    total++; if (rd !== 32'h00000099) $display("FAIL lbu got=%h exp=00000099", rd); else pass++;
    xfer(1, 3'd1, 32'h12, 0, lat, rd, er);
    total++; if (rd !== 32'hFFFF8899) $display("FAIL lh got=%h exp=ffff8899", rd); else pass++;
    xfer(1, 3'd2, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'h0000AABB) $display("FAIL lhu got=%h exp=0000aabb", rd); else pass++;
    xfer(1, 3'd3, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'hFFFFFFBB) $display("FAIL lb_lane0 got=%h exp=ffffffbb", rd); else pass++;
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] rd; logic er;
    xfer(1, 3'd7, 32'h11, 32'h00000055, lat, rd, er);
    xfer(1, 3'd0, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'h889955BB) $display("FAIL sb_merge got=%h exp=889955bb", rd); else pass++;
    xfer(1, 3'd6, 32'h12, 32'hFFFF1234, lat, rd, er);
    total++; if (er !== 1'b0) $display("FAIL sh_err got=%b exp=0", er); else pass++;
    xfer(1, 3'd0, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'h123455BB) $display("FAIL sh_merge got=%h exp=123455bb", rd); else pass++;
  endtask

  task automatic test_faults;
    int lat; logic [31:0] rd; logic er;
    xfer(1, 3'd0, 32'h6, 0, lat, rd, er);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_misaligned got=%h/%b exp=00000000/1", rd, er); else pass++;
    xfer(1, 3'd6, 32'h13, 32'hBEEF, lat, rd, er);
    total++; if (er !== 1'b1) $display("FAIL sh_misaligned got=%b exp=1", er); else pass++;
    xfer(1, 3'd0, 32'h10, 0, lat, rd, er);
    total++; if (rd !== 32'h123455BB) $display("FAIL fault_no_write got=%h exp=123455bb", rd); else pass++;
    xfer(1, 3'd0, 32'h3000, 0, lat, rd, er);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_oor got=%h/%b exp=00000000/1", rd, er); else pass++;
    xfer(1, 3'd0, 32'h2FFC, 0, lat, rd, er);
    total++; if (er !== 1'b0) $display("FAIL lw_last_word got=%b exp=0", er); else pass++;
    xfer(1, 3'd4, 32'h13, 0, lat, rd, er);
    total++; if (er !== 1'b0 || rd !== 32'h12) $display("FAIL lbu_odd got=%h/%b exp=00000012/0", rd, er); else pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] er_ = 4'b0101, ev_ = 4'b1010;
    @(negedge clk);
    m1.req_valid = 1; m1.req_op = 3'd0; m1.addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      total++; if (m1.req_ready !== er_[k]) $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, m1.req_ready, er_[k]); else pass++;
      total++; if (m1.resp_valid !== ev_[k]) $display("FAIL b2b_resp[%0d] got=%b exp=%b", k, m1.resp_valid, ev_[k]); else pass++;
      if (k == 3) m1.req_valid = 0;
      @(negedge clk);
    end
    total++; if (m1.rdata !== 32'h123455BB) $display("FAIL b2b_rdata got=%h exp=123455bb", m1.rdata); else pass++;
  endtask

  task automatic test_latency3;
    int lat; logic [31:0] rd; logic er;
    logic [7:0] er_ = 8'b00010001, ev_ = 8'b10001000;
    @(negedge clk);
    m3.req_valid = 1; m3.req_op = 3'd0; m3.addr = 32'h4;
    for (int k = 0; k < 8; k++) begin
      total++; if (m3.req_ready !== er_[k]) $display("FAIL l3_ready[%0d] got=%b exp=%b", k, m3.req_ready, er_[k]); else pass++;
      total++; if (m3.resp_valid !== ev_[k]) $display("FAIL l3_resp[%0d] got=%b exp=%b", k, m3.resp_valid, ev_[k]); else pass++;
      if (k == 7) m3.req_valid = 0;
      @(negedge clk);
    end
    xfer(3, 3'd5, 32'h8, 32'hCAFEF00D, lat, rd, er);
    total++; if (lat !== 3) $display("FAIL l3_sw_latency got=%0d exp=3", lat); else pass++;
    xfer(3, 3'd0, 32'h8, 0, lat, rd, er);
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL l3_lw got=%h exp=cafef00d", rd); else pass++;
    xfer(3, 3'd0, 32'h40, 0, lat, rd, er);
    total++; if (er !== 1'b1) $display("FAIL l3_oor got=%b exp=1", er); else pass++;
    xfer(3, 3'd0, 32'h3C, 0, lat, rd, er);
    total++; if (er !== 1'b0) $display("FAIL l3_last_word got=%b exp=0", er); else pass++;
  endtask

  task automatic test_reset_midop;
    int lat; logic [31:0] rd; logic er;
    xfer(3, 3'd0, 32'h8, 0, lat, rd, er);
    @(negedge clk);
    m3.req_valid = 1; m3.req_op = 3'd5; m3.addr = 32'h8; m3.wdata = 32'hDEADBEEF;
    @(negedge clk);
    m3.req_valid = 0;
    total++; if (m3.resp_valid !== 1'b0) $display("FAIL midop_resp1 got=%b exp=0", m3.resp_valid); else pass++;
    @(negedge clk);
    rst3 = 0;
    @(negedge clk);
    rst3 = 1;
    total++; if (m3.resp_valid !== 1'b0) $display("FAIL midop_resp2 got=%b exp=0", m3.resp_valid); else pass++;
    total++; if (m3.req_ready !== 1'b1) $display("FAIL midop_ready got=%b exp=1", m3.req_ready); else pass++;
    @(negedge clk);
    total++; if (m3.resp_valid !== 1'b0) $display("FAIL midop_resp3 got=%b exp=0", m3.resp_valid); else pass++;
    xfer(3, 3'd0, 32'h8, 0, lat, rd, er);
    total++; if (lat !== 3 || rd !== 32'h0) $display("FAIL midop_lw got=%0d/%h exp=3/00000000", lat, rd); else pass++;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_load_ext;
    test_partial_store;
    test_faults;
    test_back_to_back;
    test_latency3;
    test_reset_midop;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
